// File: rtl/iomem_sample_fifo_pkg.sv
// Shared register map and bit positions for the iomem audio sample FIFO.
package iomem_sample_fifo_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_sel_e;

    localparam int unsigned ST_EMPTY_BIT    = 16;
    localparam int unsigned ST_FULL_BIT     = 17;
    localparam int unsigned ST_UNDERRUN_BIT = 18;
    localparam int unsigned ST_OVERFLOW_BIT = 19;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;
    localparam int unsigned CTRL_FLUSH_BIT  = 2;

    localparam int unsigned THRESH_LSB      = 16;

    // Bus request captured at the sampling edge and applied one edge later.
    typedef struct packed {
        reg_sel_e    sel;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/sample_fifo_mem.sv
// DEPTH x WIDTH sample storage with wrapping pointers, level counter and flush.
module sample_fifo_mem #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        push_data_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    output logic [WIDTH-1:0]        head_data_c,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    full_c,
    output logic                    empty_c
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_c      = (level_q == LW'(DEPTH));
    assign empty_c     = (level_q == '0);
    assign head_data_c = mem_q[rd_ptr_q];
    assign level_o     = level_q;

    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        pop_ok   = pop_i && !empty_c && !flush_i;
        push_ok  = push_i && (!full_c || pop_ok) && !flush_i;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            level_d = level_q + LW'(push_ok) - LW'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage contents are don't-care after reset or flush.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/iomem_sample_fifo.sv
// iomem responder: register window, sample drain path and low-level refill irq.
module iomem_sample_fifo #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned WIDTH     = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              iomem_valid,
    output logic              iomem_ready,
    input  logic [3:0]        iomem_wstrb,
    input  logic [31:0]       iomem_addr,
    input  logic [31:0]       iomem_wdata,
    output logic [31:0]       iomem_rdata,
    input  logic              sample_req,
    output logic [WIDTH-1:0]  sample_out,
    output logic              sample_valid,
    output logic              irq
);

    import iomem_sample_fifo_pkg::*;

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    bus_req_t         req_q, req_d;
    logic             ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [WIDTH-1:0] sample_out_q, sample_out_d;
    logic             sample_valid_q, sample_valid_d;
    logic             irq_q, irq_d;
    logic             en_q, en_d;
    logic             irq_en_q, irq_en_d;
    logic [LW-1:0]    thr_q, thr_d;
    logic             underrun_q, underrun_d;
    logic             overflow_q, overflow_d;

    logic             sel_c;
    logic             wr_c;
    logic             push_c;
    logic             pop_c;
    logic             flush_c;
    logic             ctrl_wr_c;
    logic             clr_c;
    logic [15:0]      thr_wide_c;

    logic [WIDTH-1:0] head_c;
    logic [LW-1:0]    fifo_level;
    logic             full_c;
    logic             empty_c;
    logic             unused_bits;

    sample_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk         (clk),
        .rst_n       (resetn),
        .push_i      (push_c),
        .push_data_i (req_q.wdata[WIDTH-1:0]),
        .pop_i       (pop_c),
        .flush_i     (flush_c),
        .head_data_c (head_c),
        .level_o     (fifo_level),
        .full_c      (full_c),
        .empty_c     (empty_c)
    );

    // Writes are applied from the captured request during the ready cycle.
    always_comb begin
        sel_c     = iomem_valid && (iomem_addr[31:4] == BASE_ADDR[31:4]) && !ready_q;
        wr_c      = ready_q && (req_q.wstrb != 4'h0);
        push_c    = wr_c && (req_q.sel == REG_DATA);
        ctrl_wr_c = wr_c && (req_q.sel == REG_CTRL);
        clr_c     = wr_c && (req_q.sel == REG_STATUS) && req_q.wstrb[2];
        flush_c   = ctrl_wr_c && req_q.wstrb[0] && req_q.wdata[CTRL_FLUSH_BIT];
        pop_c     = sample_req && en_q && !empty_c && !flush_c;
    end

    always_comb begin
        req_d          = req_q;
        ready_d        = sel_c;
        rdata_d        = '0;
        en_d           = en_q;
        irq_en_d       = irq_en_q;
        thr_wide_c     = 16'(thr_q);
        underrun_d     = underrun_q;
        overflow_d     = overflow_q;
        sample_valid_d = sample_req;
        sample_out_d   = '0;

        if (sel_c) begin
            req_d.sel   = reg_sel_e'(iomem_addr[3:2]);
            req_d.wstrb = iomem_wstrb;
            req_d.wdata = iomem_wdata;
            case (reg_sel_e'(iomem_addr[3:2]))
                REG_STATUS: begin
                    rdata_d[LW-1:0]         = fifo_level;
                    rdata_d[ST_EMPTY_BIT]    = empty_c;
                    rdata_d[ST_FULL_BIT]     = full_c;
                    rdata_d[ST_UNDERRUN_BIT] = underrun_q;
                    rdata_d[ST_OVERFLOW_BIT] = overflow_q;
                end
                REG_CTRL: begin
                    rdata_d[CTRL_EN_BIT]       = en_q;
                    rdata_d[CTRL_IRQ_EN_BIT]   = irq_en_q;
                    rdata_d[THRESH_LSB +: LW]  = thr_q;
                end
                default: ;
            endcase
        end

        if (ctrl_wr_c) begin
            if (req_q.wstrb[0]) begin
                en_d     = req_q.wdata[CTRL_EN_BIT];
                irq_en_d = req_q.wdata[CTRL_IRQ_EN_BIT];
            end
            if (req_q.wstrb[2]) begin
                thr_wide_c[7:0] = req_q.wdata[THRESH_LSB +: 8];
            end
            if (req_q.wstrb[3]) begin
                thr_wide_c[15:8] = req_q.wdata[THRESH_LSB + 8 +: 8];
            end
        end
        thr_d = thr_wide_c[LW-1:0];

        // A new event in the same cycle as its W1C clear keeps the bit set.
        if (clr_c && req_q.wdata[ST_UNDERRUN_BIT]) begin
            underrun_d = 1'b0;
        end
        if (clr_c && req_q.wdata[ST_OVERFLOW_BIT]) begin
            overflow_d = 1'b0;
        end
        if (sample_req && en_q && empty_c && !flush_c) begin
            underrun_d = 1'b1;
        end
        if (push_c && full_c && !pop_c) begin
            overflow_d = 1'b1;
        end

        if (pop_c) begin
            sample_out_d = head_c;
        end

        irq_d = irq_en_q && (fifo_level <= thr_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_q          <= '0;
            ready_q        <= 1'b0;
            rdata_q        <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            irq_q          <= 1'b0;
            en_q           <= 1'b0;
            irq_en_q       <= 1'b0;
            thr_q          <= '0;
            underrun_q     <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            req_q          <= req_d;
            ready_q        <= ready_d;
            rdata_q        <= rdata_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
            irq_q          <= irq_d;
            en_q           <= en_d;
            irq_en_q       <= irq_en_d;
            thr_q          <= thr_d;
            underrun_q     <= underrun_d;
            overflow_q     <= overflow_d;
        end
    end

    assign iomem_ready  = ready_q;
    assign iomem_rdata  = rdata_q;
    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign irq          = irq_q;

    assign unused_bits = ^{iomem_addr[1:0], req_q.wdata, thr_wide_c};

endmodule

// File: doc/iomem_sample_fifo.md
# iomem_sample_fifo

Memory-mapped audio sample FIFO that sits on the SoC `iomem_*` bus as a responder: the CPU writes PCM samples through a register window, and the audio datapath drains one sample per `sample_req` strobe. It provides buffering between firmware and the fixed-rate codec path, plus a refill interrupt on low level. The CPU is the only initiator; this block only responds.

## Interface
- `BASE_ADDR`, 32'h0300_0000, register window base; 16-byte aligned.
- `DEPTH`, 64, FIFO entries; power of two, 4..256.
- `WIDTH`, 16, sample width; 1..32.
- `LW` (derived), log2(DEPTH)+1, level counter width.

Clock and reset:
- One clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous active-low reset.

Bus and sample ports:
- `iomem_valid`  in  1  bus request.
- `iomem_ready`  out  1  one-cycle completion pulse.
- `iomem_wstrb`  in  4  byte write strobes; 0 means a read.
- `iomem_addr`  in  32  byte address.
- `iomem_wdata`  in  32  write data.
- `iomem_rdata`  out  32  read data; valid while `iomem_ready` is high.
- `sample_req`  in  1  single-cycle drain strobe from the codec side.
- `sample_out`  out  WIDTH  drained sample.
- `sample_valid`  out  1  one-cycle pulse qualifying `sample_out`.
- `irq`  out  1  level interrupt, refill request.

## Operation
- Select: `iomem_valid && iomem_addr[31:4] == BASE_ADDR[31:4] && !iomem_ready`. Other addresses are never acknowledged.
- Registers are selected by `iomem_addr[3:2]`:
  - 0, DATA: a write with any strobe set pushes `wdata[WIDTH-1:0]`. A read returns 0.
  - 1, STATUS (read-only except for the W1C bits):
    - [LW-1:0] level, zero-extended.
    - bit 16 empty; bit 17 full.
    - bit 18 underrun, sticky; bit 19 overflow, sticky.
    - A write with `wstrb[2]` set clears bit 18 and/or bit 19 where `wdata` holds a 1.
  - 2, CTRL (byte-strobed):
    - bit 0 enable; bit 1 irq_en.
    - bit 2 flush, self-clearing, reads 0.
    - [31:16] threshold; only the low LW bits are used, upper bits read 0.
  - 3: reserved. Reads return 0; writes are ignored.
- Push:
  - Accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the data is dropped and overflow is set.
  - `iomem_ready` is still given in both cases.
- Drain, on `sample_req`:
  - enable=1 and not empty: pop the head, `sample_out`=head.
  - enable=1 and empty: `sample_out`=0, underrun set. A push in the same cycle still lands; there is no bypass.
  - enable=0: `sample_out`=0, no pop, no underrun.
  - `sample_valid` pulses in every case.
- Flush: clears the pointers and sets level to 0; the stored data is don't-care. If a drain coincides with a flush, the flush wins: the output is 0 and underrun is not set.
- `irq` = irq_en && level <= threshold, registered.
- Level arithmetic is unsigned LW-bit. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.

## Timing
- Reset values:
  - All outputs 0: `iomem_ready`, `iomem_rdata`, `sample_out`, `sample_valid`, `irq`.
  - CTRL 0, threshold 0, stickies 0, level 0, pointers 0.
- Bus:
  - `iomem_valid` is sampled at edge N; `iomem_ready` is high for exactly cycle N+1, with `iomem_rdata` registered.
  - The register or FIFO update lands at edge N+1.
  - A back-to-back request is sampled no earlier than the edge after the ready pulse.
- Drain: `sample_req` at edge N; `sample_out`/`sample_valid` are valid in cycle N+1, and the level is decremented by edge N+1.
- STATUS read: reflects the state at edge N, before this cycle's push or pop.
- `irq`: follows a level or CTRL change by one cycle.
- Reset asserted mid-transaction: outputs clear immediately, and a pending ready is lost. The initiator is reset by the same `resetn`.

## Structure
- Package `iomem_sample_fifo_pkg` holds:
  - register offsets (DATA=0, STATUS=1, CTRL=2);
  - STATUS/CTRL bit positions;
  - the threshold field LSB.
- Sub-module `sample_fifo_mem`: DEPTH×WIDTH storage, read/write pointers, level counter, push/pop/flush inputs, full/empty outputs.
- Top level holds the bus decode, registers, drain logic and irq.

## Test plan
- Reset, then read STATUS → 0x0001_0000 (empty). CTRL reads 0, `irq`=0.
- Set CTRL enable=1. Write DATA 0x1234 then 0xABCD; issue `sample_req` twice → `sample_out` 0x1234 then 0xABCD, each with a one-cycle `sample_valid`. STATUS level then returns to 0.
- Fill 64 entries, push a 65th → STATUS full=1, overflow=1, level=64, and the 65th value is never drained. A W1C write of 0x0008_0000 clears overflow.
- With enable=1 and the FIFO empty, `sample_req` → `sample_out`=0, underrun=1. With enable=0, `sample_req` → `sample_out`=0, underrun unchanged.
- CTRL = threshold 4, irq_en=1 → `irq`=1. Push 5 samples → `irq`=0. Drain one → `irq`=1 one cycle later.
- Simultaneous cases:
  - Full FIFO with a DATA write and `sample_req` in the same cycle → push accepted, level stays 64, no overflow.
  - Flush in the same cycle as `sample_req` → `sample_out`=0, level=0, underrun=0.
